// File: rtl/rsa_msg_sequencer.sv
// Sequences plaintext symbols through a modular-exponentiation core: load operands, pulse start,
// wait (with timeout) for done, return result on a valid/ready stream. One symbol in flight.
module rsa_msg_sequencer #(
  parameter int base_width = 4,
  parameter int expo_width = 4,
  parameter int N_width    = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_load,
  input  logic [expo_width-1:0] key_expo,
  input  logic [N_width-1:0]    key_N,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [base_width-1:0] in_data,
  output logic                  core_start,
  output logic [base_width-1:0] core_base,
  output logic [expo_width-1:0] core_expo,
  output logic [N_width-1:0]    core_N,
  input  logic [N_width-1:0]    core_result,
  input  logic                  core_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_width-1:0]    out_data,
  output logic                  out_err,
  output logic                  busy,
  output logic [7:0]            msg_count
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    GUARD = 3'd2,
    WAIT  = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t                state;
  logic [expo_width-1:0] key_expo_r;
  logic [N_width-1:0]    key_N_r;
  logic                  key_ok;
  logic [base_width-1:0] base_r;
  logic [N_width-1:0]    res_r;
  logic                  err_r;
  logic [TW-1:0]         timer;
  logic                  core_start_r;
  logic                  out_valid_r;
  logic [7:0]            msg_count_r;
  logic                  accept;

  // key_load wins over a symbol offered in the same IDLE cycle
  assign in_ready = (state == IDLE) && key_ok && !key_load;
  assign accept   = in_valid && in_ready;

  assign core_start = core_start_r;
  assign core_base  = base_r;
  assign core_expo  = key_expo_r;
  assign core_N     = key_N_r;
  assign out_valid  = out_valid_r;
  assign out_data   = res_r;
  assign out_err    = err_r;
  assign busy       = (state != IDLE);
  assign msg_count  = msg_count_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      key_expo_r   <= '0;
      key_N_r      <= '0;
      key_ok       <= 1'b0;
      base_r       <= '0;
      res_r        <= '0;
      err_r        <= 1'b0;
      timer        <= '0;
      core_start_r <= 1'b1;
      out_valid_r  <= 1'b0;
      msg_count_r  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (key_load) begin
            key_expo_r <= key_expo;
            key_N_r    <= key_N;
            key_ok     <= 1'b1;
          end else if (accept) begin
            base_r <= in_data;
            state  <= START;
          end
        end
        START: begin
          core_start_r <= 1'b0;
          state        <= GUARD;
        end
        GUARD: begin
          // core done may still reflect the previous operation here
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (core_valid) begin
            res_r       <= core_result;
            err_r       <= 1'b0;
            out_valid_r <= 1'b1;
            state       <= OUT;
          end else if (timer == TIMER_LAST) begin
            res_r       <= '0;
            err_r       <= 1'b1;
            out_valid_r <= 1'b1;
            state       <= OUT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_r  <= 1'b0;
            core_start_r <= 1'b1;
            msg_count_r  <= msg_count_r + 8'd1;
            state        <= IDLE;
          end
        end
        default: begin
          out_valid_r  <= 1'b0;
          core_start_r <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_msg_sequencer.sv
// Bench for rsa_msg_sequencer: behavioural core model, cycle-level reference model checked every
// cycle, a vector table of transactions, hand-written corner sequences and a random soak.
module tb_rsa_msg_sequencer;

  localparam int TIMEOUT = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_load;
  logic [3:0] key_expo, key_N;
  logic       in_valid, in_ready;
  logic [3:0] in_data;
  logic       core_start;
  logic [3:0] core_base, core_expo, core_N;
  logic [3:0] core_result = 4'd0;
  logic       core_valid  = 1'b0;
  logic       out_valid, out_ready;
  logic [3:0] out_data;
  logic       out_err, busy;
  logic [7:0] msg_count;

  always #5 clk = ~clk;

  rsa_msg_sequencer #(.base_width(4), .expo_width(4), .N_width(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_expo(key_expo), .key_N(key_N),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_start(core_start), .core_base(core_base), .core_expo(core_expo), .core_N(core_N),
    .core_result(core_result), .core_valid(core_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .busy(busy), .msg_count(msg_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic logic [3:0] modexp(input logic [3:0] b, input logic [3:0] e, input logic [3:0] n);
    int r;
    if (n == 4'd0) return 4'd0;
    r = 1 % int'(n);
    for (int i = 0; i < int'(e); i++) r = (r * int'(b)) % int'(n);
    return 4'(r);
  endfunction

  // Core model: restarts while start is high, keeps its last done/result (stale) until the
  // first cycle after start drops, then asserts done in cycle (GUARD+1+lat) unless hung.
  int core_lat = 0;
  bit core_hang = 1'b0;
  int c_cnt = 0, c_lat = 0;
  bit c_hang = 1'b0;
  logic [3:0] c_b = 4'd0, c_e = 4'd0, c_n = 4'd0;

  always @(posedge clk) begin
    if (core_start) begin
      c_cnt  <= 0;
      c_lat  <= core_lat;
      c_hang <= core_hang;
      c_b    <= core_base;
      c_e    <= core_expo;
      c_n    <= core_N;
    end else begin
      c_cnt <= c_cnt + 1;
      if (!c_hang && (c_cnt + 1 > c_lat)) begin
        core_valid  <= 1'b1;
        core_result <= modexp(c_b, c_e, c_n);
      end else begin
        core_valid <= 1'b0;
      end
    end
  end

  // Reference model: transaction-level view with expected output cycle.
  bit         m_key_ok = 1'b0, m_busy = 1'b0, m_err = 1'b0;
  logic [3:0] m_expo = 4'd0, m_N = 4'd0, m_base = 4'd0, m_res = 4'd0;
  logic [7:0] m_cnt = 8'd0;
  int         m_acc = 0, m_rdy = 0;
  bit         acc_flag, hs_flag, hs_err;
  logic [3:0] hs_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    bit exp_ov;
    @(negedge clk);
    exp_ov = m_busy && (cyc >= m_rdy);
    chk("in_ready", 32'(in_ready), 32'(!m_busy && m_key_ok && !key_load));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("core_start", 32'(core_start), 32'(!m_busy || cyc == m_acc + 1));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("msg_count", 32'(msg_count), 32'(m_cnt));
    if (exp_ov) begin
      chk("out_data", 32'(out_data), 32'(m_res));
      chk("out_err", 32'(out_err), 32'(m_err));
    end
    if (m_busy) begin
      chk("core_base", 32'(core_base), 32'(m_base));
      chk("core_expo", 32'(core_expo), 32'(m_expo));
      chk("core_N", 32'(core_N), 32'(m_N));
    end
    if (rst) begin
      m_key_ok = 0; m_busy = 0; m_cnt = 8'd0;
    end else if (!m_busy) begin
      if (key_load) begin
        m_key_ok = 1; m_expo = key_expo; m_N = key_N;
      end else if (in_valid && m_key_ok) begin
        m_busy = 1; m_acc = cyc; m_base = in_data; acc_flag = 1;
        m_err = core_hang || (core_lat > TIMEOUT - 1);
        m_res = m_err ? 4'd0 : modexp(in_data, m_expo, m_N);
        m_rdy = m_err ? cyc + 3 + TIMEOUT : cyc + 4 + core_lat;
      end
    end else if (exp_ov && out_ready) begin
      m_busy = 0; m_cnt = m_cnt + 8'd1;
      hs_flag = 1; hs_data = out_data; hs_err = out_err;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_key(input logic [3:0] e, input logic [3:0] n);
    key_load = 1'b1; key_expo = e; key_N = n;
    tick();
    key_load = 1'b0;
  endtask

  task automatic send(input logic [3:0] b, input int lat, input bit hang, input int stall,
                      output logic [3:0] d, output bit e);
    int n, st;
    st = stall;
    core_lat = lat; core_hang = hang;
    in_data = b; in_valid = 1'b1; acc_flag = 0; n = 0;
    while (!acc_flag && n < 20) begin tick(); n++; end
    in_valid = 1'b0;
    hs_flag = 0; n = 0;
    while (acc_flag && !hs_flag && n < 120) begin
      if (out_valid && st > 0) begin out_ready = 1'b0; st--; end
      else out_ready = 1'b1;
      tick(); n++;
    end
    out_ready = 1'b1;
    chk("txn_completed", 32'(acc_flag && hs_flag), 32'd1);
    d = hs_data; e = hs_err;
  endtask

  typedef struct {
    logic [3:0] expo, n, base;
    int         lat;
    bit         hang;
    int         stall;
    logic [3:0] data;
    bit         err;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic [3:0] d;
    bit e;

    vt[0] = '{4'd3,  4'd7,  4'd2,  2,  1'b0, 0, 4'd1, 1'b0};
    vt[1] = '{4'd4,  4'd11, 4'd3,  0,  1'b0, 0, 4'd4, 1'b0};
    vt[2] = '{4'd4,  4'd11, 4'd5,  5,  1'b0, 0, 4'd9, 1'b0};
    vt[3] = '{4'd4,  4'd11, 4'd6,  0,  1'b1, 0, 4'd0, 1'b1};
    vt[4] = '{4'd4,  4'd11, 4'd7,  31, 1'b0, 0, 4'd3, 1'b0};
    vt[5] = '{4'd4,  4'd11, 4'd7,  32, 1'b0, 0, 4'd0, 1'b1};
    vt[6] = '{4'd0,  4'd7,  4'd9,  1,  1'b0, 5, 4'd1, 1'b0};
    vt[7] = '{4'd15, 4'd13, 4'd15, 3,  1'b0, 2, 4'd8, 1'b0};
    vt[8] = '{4'd2,  4'd1,  4'd3,  0,  1'b0, 0, 4'd0, 1'b0};

    rst = 1'b1; key_load = 1'b0; key_expo = 4'd0; key_N = 4'd0;
    in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_core_base", 32'(core_base), 32'd0);
    chk("rst_core_expo", 32'(core_expo), 32'd0);
    chk("rst_core_N", 32'(core_N), 32'd0);
    tick();
    rst = 1'b0;

    // no key yet: symbols must be refused
    in_valid = 1'b1; in_data = 4'd2;
    repeat (10) tick();
    // key_load and symbol together: key taken, symbol not
    key_load = 1'b1; key_expo = 4'd3; key_N = 4'd7;
    tick();
    key_load = 1'b0; in_valid = 1'b0;
    chk("no_accept_with_key_load", 32'(busy), 32'd0);

    for (int i = 0; i < 9; i++) begin
      if (vt[i].expo != m_expo || vt[i].n != m_N) load_key(vt[i].expo, vt[i].n);
      send(vt[i].base, vt[i].lat, vt[i].hang, vt[i].stall, d, e);
      chk("vec_data", 32'(d), 32'(vt[i].data));
      chk("vec_err", 32'(e), 32'(vt[i].err));
      if (i == 0) chk("first_msg_count", 32'(msg_count), 32'd1);
    end

    // key_load while busy is ignored; result uses the old key (3^3 mod 7)
    load_key(4'd3, 4'd7);
    core_lat = 6; core_hang = 1'b0; in_data = 4'd3; in_valid = 1'b1; acc_flag = 0;
    for (int n = 0; n < 5 && !acc_flag; n++) tick();
    in_valid = 1'b0;
    key_load = 1'b1; key_expo = 4'd1; key_N = 4'd5;
    repeat (3) tick();
    key_load = 1'b0;
    hs_flag = 0;
    for (int n = 0; n < 40 && !hs_flag; n++) tick();
    chk("busy_key_ignored_data", 32'(hs_data), 32'd6);
    chk("busy_key_ignored_expo", 32'(core_expo), 32'd3);

    // reset while waiting on the core
    core_lat = 20; in_data = 4'd4; in_valid = 1'b1; acc_flag = 0;
    for (int n = 0; n < 5 && !acc_flag; n++) tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_core_start", 32'(core_start), 32'd1);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_msg_count", 32'(msg_count), 32'd0);
    in_valid = 1'b1;
    repeat (3) begin
      chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      key_load  = ($urandom_range(0, 9) == 0);
      key_expo  = 4'($urandom);
      key_N     = 4'($urandom);
      in_valid  = ($urandom_range(0, 9) < 6);
      in_data   = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      if (!m_busy) begin
        core_hang = ($urandom_range(0, 9) == 0);
        core_lat  = $urandom_range(0, 33);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_msg_sequencer.md
# rsa_msg_sequencer

Upstream sequencer for the modular-exponentiation core. It holds the public key (exponent, modulus), accepts plaintext symbols over a valid/ready stream, and drives one exponentiation per symbol: it loads the operands, pulses the core's start, and waits for the core's valid. It returns each result on a valid/ready output stream, with a timeout error flag if the core never completes.

## Interface
Parameters:
- base_width, 4, plaintext symbol width (matches core base)
- expo_width, 4, exponent width (matches core expo)
- N_width, 4, modulus/result width (matches core N/result)
- TIMEOUT, 32, max WAIT cycles before error; must exceed 2^expo_width+2

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- key_load  in  1  load key_expo/key_N into key registers
- key_expo  in  expo_width  exponent to store
- key_N  in  N_width  modulus to store
- in_valid  in  1  plaintext symbol present
- in_ready  out  1  sequencer accepts symbol
- in_data  in  base_width  plaintext symbol
- core_start  out  1  core start/reset (core computes while low)
- core_base  out  base_width  registered symbol to core
- core_expo  out  expo_width  stored exponent to core
- core_N  out  N_width  stored modulus to core
- core_result  in  N_width  core result
- core_valid  in  1  core done
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  N_width  registered result (0 on error)
- out_err  out  1  result produced by timeout, qualified by out_valid
- busy  out  1  state != IDLE
- msg_count  out  8  completed handshakes on output, wraps 255->0

## Operation
- Registers: key_expo_r, key_N_r, key_ok, base_r, res_r, err_r, timer, msg_count, state.
- key_ok: cleared by rst; set by the first accepted key_load.
- key_load is accepted only in IDLE. It has priority over input: in_ready = (state==IDLE) & key_ok & ~key_load. key_load outside IDLE is ignored; the key stays unchanged.
- core_expo/core_N come directly from the key registers. core_base = base_r. All are stable from START through WAIT.
- FSM:
  - IDLE: core_start=1 (core held quiescent). On in_valid&in_ready: base_r<=in_data, go to START.
  - START: core_start=1 for this one cycle with the new operands. Go to GUARD.
  - GUARD: core_start=0. core_valid is ignored, since the core's done may be stale for one cycle. timer<=0. Go to WAIT.
  - WAIT: core_start=0.
    - If core_valid: res_r<=core_result, err_r<=0, go to OUT.
    - Else if timer==TIMEOUT-1: res_r<=0, err_r<=1, go to OUT.
    - Else timer<=timer+1.
  - OUT: core_start=0, out_valid=1, out_data=res_r, out_err=err_r. On out_ready: msg_count<=msg_count+1 (mod 256), go to IDLE.
- out_data/out_err are held unchanged while out_valid=1 and out_ready=0.
- Special cases (N<=1, expo=0) are resolved by the core. The sequencer passes core_result through verbatim.

## Timing
- Reset values:
  - state=IDLE, so core_start=1
  - in_ready=0, since key_ok=0
  - out_valid=0, out_data=0, out_err=0, busy=0, msg_count=0
  - base_r=0, key registers=0, timer=0
- rst mid-operation returns to IDLE next edge, discards the in-flight symbol and any pending output, and clears key_ok. The key must be reloaded.
- Input accepted at edge 0 -> START during cycle 1 -> GUARD cycle 2 -> WAIT from cycle 3.
- core_valid first sampled at cycle 3. out_valid rises the cycle after the sampling edge that sees core_valid=1.
- Timeout: with no core_valid, out_valid rises in cycle 3+TIMEOUT.
- Throughput: one symbol per (4 + core latency + output-stall) cycles. No overlap; in_ready=0 whenever busy.
- Output handshake at edge k -> in_ready=1 in cycle k+1 (if key_ok and no key_load).

## Test plan
- Key expo=3, N=7 loaded; symbol 2 sent; core model returns 2^3 mod 7 -> out_data=1, out_err=0, msg_count=1. core_start is low from cycle 2 until return to IDLE.
- Key expo=4, N=11; symbols 3 then 5 back-to-back with out_ready=1 -> outputs 4 then 9 in order. in_ready stays low between acceptance and output handshake.
- Before any key_load, in_valid=1 for 10 cycles -> in_ready stays 0, no core_start falling edge. key_load with in_valid in the same IDLE cycle -> key taken, symbol not accepted that cycle.
- Core model never asserts core_valid -> out_valid at cycle 3+32 with out_data=0, out_err=1. The next symbol is processed normally.
- out_ready held low 5 cycles in OUT -> out_data/out_err stable. key_load during WAIT/OUT is ignored: the next result still uses the old key.
- rst asserted during WAIT -> next cycle state IDLE, core_start=1, out_valid=0, msg_count=0, in_ready=0 until key reloaded.
